// File: rtl/rio_pkg.sv
// Shared types for the IO pad-ring power sequencer: FSM state encoding and gate output decode.
package rio_pkg;

  typedef enum logic [3:0] {
    OFF, QUAL, REL_RET, EN_IE, EN_OE, ON, DIS_OE, DIS_IE, ASSERT_RET, FAULT
  } rio_seq_state_e;

  typedef struct packed {
    logic ret_n;
    logic ie_en;
    logic oe_en;
    logic ready;
    logic busy;
    logic fault;
  } rio_gates_t;

  // Gates nest: oe implies ie implies ret_n, in every state.
  function automatic rio_gates_t rio_decode(rio_seq_state_e s);
    rio_gates_t g;
    g = '0;
    case (s)
      QUAL:       g.busy = 1'b1;
      REL_RET:    begin g.ret_n = 1'b1; g.busy = 1'b1; end
      EN_IE:      begin g.ret_n = 1'b1; g.ie_en = 1'b1; g.busy = 1'b1; end
      EN_OE:      begin g.ret_n = 1'b1; g.ie_en = 1'b1; g.oe_en = 1'b1; g.busy = 1'b1; end
      ON:         begin g.ret_n = 1'b1; g.ie_en = 1'b1; g.oe_en = 1'b1; g.ready = 1'b1; end
      DIS_OE:     begin g.ret_n = 1'b1; g.ie_en = 1'b1; g.busy = 1'b1; end
      DIS_IE:     begin g.ret_n = 1'b1; g.busy = 1'b1; end
      ASSERT_RET: g.busy = 1'b1;
      FAULT:      g.fault = 1'b1;
      default:    g = '0;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/rio_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a parameterised reset value.
module rio_sync2 #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sync_q <= {2{RST_VAL}};
    else         sync_q <= {sync_q[0], d_i};
  end

  assign q_o = sync_q[1];

endmodule

// File: rtl/rio_ring_pwr_seq.sv
// GF22FDX IO ring power sequencer: qualifies VDDIO-good, then steps retention -> IE -> OE
// up and the reverse down, dropping straight to a sticky fault state on VDDIO loss.
module rio_ring_pwr_seq
  import rio_pkg::*;
#(
  parameter int STABLE_CYC = 16,
  parameter int STEP_CYC   = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic vddio_ok_i,
  output logic ret_n_o,
  output logic ie_en_o,
  output logic oe_en_o,
  output logic ready_o,
  output logic busy_o,
  output logic fault_o
);

  localparam int MAX_CYC = (STABLE_CYC > STEP_CYC) ? STABLE_CYC : STEP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYC - 1);

  rio_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  rio_gates_t       gates_q;
  logic             vok;
  logic             step_done;

  rio_sync2 #(.RST_VAL(1'b0)) u_vok_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (vddio_ok_i),
    .q_o    (vok)
  );

  assign step_done = (cnt_q == STEP_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    case (state_q)
      OFF:        if (en_i && vok) state_d = QUAL;
      QUAL: begin
        if (!en_i)                     state_d = OFF;
        else if (!vok)                 cnt_d   = '0;
        else if (cnt_q == STABLE_LAST) state_d = REL_RET;
      end
      REL_RET: begin
        if (!vok)           state_d = FAULT;
        else if (!en_i)     state_d = ASSERT_RET;
        else if (step_done) state_d = EN_IE;
      end
      EN_IE: begin
        if (!vok)           state_d = FAULT;
        else if (!en_i)     state_d = DIS_IE;
        else if (step_done) state_d = EN_OE;
      end
      EN_OE: begin
        if (!vok)       state_d = FAULT;
        else if (!en_i) state_d = DIS_OE;
        else            state_d = ON;
      end
      ON: begin
        if (!vok)       state_d = FAULT;
        else if (!en_i) state_d = DIS_OE;
      end
      // Power-down ignores en_i re-assertion until OFF is reached.
      DIS_OE: begin
        if (!vok)           state_d = FAULT;
        else if (step_done) state_d = DIS_IE;
      end
      DIS_IE: begin
        if (!vok)           state_d = FAULT;
        else if (step_done) state_d = ASSERT_RET;
      end
      ASSERT_RET: state_d = vok ? OFF : FAULT;
      FAULT:      if (!en_i) state_d = OFF;
      default:    state_d = OFF;
    endcase
    if (state_d != state_q || state_d inside {OFF, ON, FAULT}) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= OFF;
      cnt_q   <= '0;
      gates_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gates_q <= rio_decode(state_d);
    end
  end

  assign ret_n_o = gates_q.ret_n;
  assign ie_en_o = gates_q.ie_en;
  assign oe_en_o = gates_q.oe_en;
  assign ready_o = gates_q.ready;
  assign busy_o  = gates_q.busy;
  assign fault_o = gates_q.fault;

  a_gate_order: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (!oe_en_o || ie_en_o) && (!ie_en_o || ret_n_o));

endmodule

// File: tb/tb_rio_ring_pwr_seq.sv
// Directed bench for rio_ring_pwr_seq: edge k of a run is the k-th clock edge sampling that run's inputs.
module tb_rio_ring_pwr_seq;

  logic clk = 1'b0;
  logic rst_n, en, vdd;
  logic ret_n, ie_en, oe_en, ready, busy, fault;
  logic [5:0] o;
  int n_vec = 0, n_err = 0;
  int fst [6];
  int lst [6];
  logic inv_bad = 1'b0;

  localparam int RET = 0, IE = 1, OE = 2, RDY = 3, BSY = 4, FLT = 5;

  always #5 clk = ~clk;

  rio_ring_pwr_seq #(.STABLE_CYC(16), .STEP_CYC(4)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .vddio_ok_i (vdd),
    .ret_n_o    (ret_n),
    .ie_en_o    (ie_en),
    .oe_en_o    (oe_en),
    .ready_o    (ready),
    .busy_o     (busy),
    .fault_o    (fault)
  );

  assign o = {fault, busy, ready, oe_en, ie_en, ret_n};

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // First/last edge on which output bit b changed during the last run (-1 = never).
  task automatic chk_chg(input string tag, input int b, input int f, input int l);
    chk({tag, "_first"}, fst[b], f);
    chk({tag, "_last"}, lst[b], l);
  endtask

  // vdd is low on edges vlo_a..vlo_b, en low from edge en_lo (0 = never), else the base values.
  task automatic run(input int n, input logic vb, input logic eb,
                     input int vlo_a, input int vlo_b, input int en_lo);
    logic [5:0] prev;
    prev = o;
    for (int b = 0; b < 6; b++) begin fst[b] = -1; lst[b] = -1; end
    for (int k = 1; k <= n; k++) begin
      vdd = (k >= vlo_a && k <= vlo_b) ? 1'b0 : vb;
      en  = (en_lo > 0 && k >= en_lo) ? 1'b0 : eb;
      @(posedge clk); #1;
      for (int b = 0; b < 6; b++)
        if (o[b] != prev[b]) begin
          if (fst[b] < 0) fst[b] = k;
          lst[b] = k;
        end
      prev = o;
      if ((oe_en && !ie_en) || (ie_en && !ret_n)) inv_bad = 1'b1;
    end
  endtask

  task automatic idle();
    en = 1'b0; vdd = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; vdd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", int'(o), 0);
    en = 1'b1; vdd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hold", int'(o), 0);
    rst_n = 1'b1;
    idle();

    // Clean power-up: QUAL at 3, REL_RET 19, EN_IE 23, EN_OE 27, ON 28.
    run(30, 1'b1, 1'b1, 0, -1, 0);
    chk_chg("up_ret", RET, 19, 19);
    chk_chg("up_ie", IE, 23, 23);
    chk_chg("up_oe", OE, 27, 27);
    chk_chg("up_rdy", RDY, 28, 28);
    chk_chg("up_busy", BSY, 3, 28);
    chk_chg("up_flt", FLT, -1, -1);
    chk("up_on", int'(o), 6'b001111);

    // Clean power-down from ON.
    run(15, 1'b1, 1'b0, 0, -1, 0);
    chk_chg("dn_oe", OE, 1, 1);
    chk_chg("dn_rdy", RDY, 1, 1);
    chk_chg("dn_ie", IE, 5, 5);
    chk_chg("dn_ret", RET, 9, 9);
    chk_chg("dn_busy", BSY, 1, 10);
    chk("dn_off", int'(o), 0);
    idle();

    // Glitch sampled on edges 10..11 is seen by the FSM on 12..13; 16 good cycles from 14.
    run(40, 1'b1, 1'b1, 10, 11, 0);
    chk_chg("gl_ret", RET, 29, 29);
    chk_chg("gl_rdy", RDY, 38, 38);
    chk_chg("gl_flt", FLT, -1, -1);
    chk("gl_on", int'(o), 6'b001111);
    run(15, 1'b1, 1'b0, 0, -1, 0);
    chk("gl_dn_off", int'(o), 0);
    idle();

    // Abort during EN_IE (edges 23..26): en low on 24 -> DIS_IE, ASSERT_RET 28, OFF 29.
    run(35, 1'b1, 1'b1, 0, -1, 24);
    chk_chg("ab_ret", RET, 19, 28);
    chk_chg("ab_ie", IE, 23, 24);
    chk_chg("ab_oe", OE, -1, -1);
    chk_chg("ab_busy", BSY, 3, 29);
    chk("ab_off", int'(o), 0);
    idle();

    // VDDIO loss in ON: low sampled on edge 1, FAULT on edge 3.
    run(30, 1'b1, 1'b1, 0, -1, 0);
    chk("ls_on", int'(o), 6'b001111);
    run(10, 1'b0, 1'b1, 0, -1, 0);
    chk_chg("ls_ret", RET, 3, 3);
    chk_chg("ls_oe", OE, 3, 3);
    chk_chg("ls_flt", FLT, 3, 3);
    chk("ls_fault", int'(o), 6'b100000);
    run(5, 1'b1, 1'b1, 0, -1, 0);
    chk_chg("ls_sticky", FLT, -1, -1);
    run(3, 1'b1, 1'b0, 0, -1, 0);
    chk_chg("ls_clear", FLT, 1, 1);
    chk("ls_off", int'(o), 0);
    idle();

    // Reset while in EN_OE, then full restart.
    run(27, 1'b1, 1'b1, 0, -1, 0);
    chk("rs_en_oe", int'(o), 6'b010111);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rs_outs", int'(o), 0);
    rst_n = 1'b1;
    run(30, 1'b1, 1'b1, 0, -1, 0);
    chk_chg("rs_ret", RET, 19, 19);
    chk_chg("rs_rdy", RDY, 28, 28);

    chk("gate_order", int'(inv_bad), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
